mem_access_unit: RTL and testbench

- Load/store controller directly upstream of the 16-bit data memory in the RISC datapath.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake and drives the data memory's addr/write_data/write_en/read_en.
- Performs byte stores as read-modify-write, sign-extends byte loads, range-checks addresses and returns a registered response to writeback.

---
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller in front of the 16-bit data memory with byte RMW and range checking
module mem_access_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DATA_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_byte_sel,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
  localparam logic [1:0] OP_LW = 2'd0, OP_SW = 2'd1, OP_LB = 2'd2, OP_SB = 2'd3;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(DATA_DEPTH);
  state_t state_q;
  logic [1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic sel_q;
  logic [DATA_W-1:0] wdata_q, buf_q, rsp_data_q;
  logic rsp_valid_q, rsp_err_q;
  logic acc, rmw, sw_wr;
  logic [7:0] rd_byte;
  logic [DATA_W-1:0] merged;
  // memory-side decode; rst masks every strobe so nothing reaches memory during reset
  always_comb begin
    acc = state_q == ACCESS && !rst;
    rmw = state_q == RMW_WR && !rst;
    sw_wr = acc && op_q == OP_SW;
    rd_byte = sel_q ? mem_read_data[15:8] : mem_read_data[7:0];
    merged = sel_q ? {wdata_q[7:0], buf_q[7:0]} : {buf_q[15:8], wdata_q[7:0]};
  end
  assign req_ready      = state_q == IDLE && !rst;
  assign mem_addr       = (acc || rmw) ? addr_q : '0;
  assign mem_read_en    = acc && op_q != OP_SW;
  assign mem_write_en   = sw_wr || rmw;
  assign mem_write_data = rmw ? merged : sw_wr ? wdata_q : '0;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  // request FSM with registered response; out-of-range requests skip straight to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            sel_q   <= req_byte_sel;
            wdata_q <= req_wdata;
            if ({1'b0, req_addr} >= DEPTH) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (op_q == OP_SB) begin
            buf_q   <= mem_read_data;
            state_q <= RMW_WR;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= op_q == OP_LW ? mem_read_data :
                           op_q == OP_LB ? {{(DATA_W-8){rd_byte[7]}}, rd_byte} : '0;
          end
        end
        RMW_WR: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a word-array reference model
module tb_mem_access_unit;
  localparam logic [1:0] LW = 2'd0, SW = 2'd1, LB = 2'd2, SB = 2'd3;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_byte_sel = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic rsp_valid, rsp_err, mem_write_en, mem_read_en;
  logic [15:0] rsp_data, mem_addr, mem_write_data, mem_read_data;
  logic [15:0] mem [256] = '{default: 16'h0};
  logic [15:0] ref_mem [256] = '{default: 16'h0};
  logic [16:0] eq [$];
  int n = 0, fails = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_byte_sel(req_byte_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = (mem_addr < 16'd256) ? mem[mem_addr[7:0]] : 16'h0;
  always @(posedge clk) if (mem_write_en && mem_addr < 16'd256) mem[mem_addr[7:0]] <= mem_write_data;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference behaviour: {err, data} for one request, applying stores to ref_mem
  task automatic predict(input logic [1:0] op, input logic [15:0] a, input logic s,
                         input logic [15:0] wd, output logic [16:0] r);
    logic [15:0] w;
    logic [7:0] b;
    if (a >= 16'd256) begin
      r = {1'b1, 16'h0};
      return;
    end
    w = ref_mem[a[7:0]];
    b = s ? w[15:8] : w[7:0];
    r = 17'h0;
    case (op)
      LW: r = {1'b0, w};
      SW: ref_mem[a[7:0]] = wd;
      LB: r = {1'b0, {8{b[7]}}, b};
      default: ref_mem[a[7:0]] = s ? {wd[7:0], w[7:0]} : {w[15:8], wd[7:0]};
    endcase
  endtask

  task automatic scramble;
    req_op = 2'($urandom);
    req_addr = 16'($urandom);
    req_byte_sel = 1'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic s, input logic [15:0] wd);
    logic [16:0] e;
    logic inr, got, rerr;
    logic [15:0] wa, wdat, rdat;
    int lat, wr, rd, both, wr_at, exp_lat;
    inr = a < 16'd256;
    exp_lat = !inr ? 1 : (op == SB ? 3 : 2);
    predict(op, a, s, wd, e);
    req_valid = 1'b1; req_op = op; req_addr = a; req_byte_sel = s; req_wdata = wd;
    chk("ready", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    scramble;
    lat = 0; got = 0; wr = 0; rd = 0; both = 0; wr_at = 0;
    wa = 0; wdat = 0; rdat = 0; rerr = 0;
    while (!got && lat < 8) begin
      lat++;
      if (mem_write_en) begin wr++; wr_at = lat; wa = mem_addr; wdat = mem_write_data; end
      if (mem_read_en) rd++;
      if (mem_write_en && mem_read_en) both++;
      if (rsp_valid) begin got = 1; rdat = rsp_data; rerr = rsp_err; end
      else tick;
    end
    chk("rsp_seen", 32'(got), 1);
    chk("latency", lat, exp_lat);
    chk("rsp_data", 32'(rdat), 32'(e[15:0]));
    chk("rsp_err", 32'(rerr), 32'(e[16]));
    chk("wr_cnt", wr, (inr && op[0]) ? 1 : 0);
    chk("rd_cnt", rd, (inr && op != SW) ? 1 : 0);
    chk("rw_excl", both, 0);
    if (inr && op[0]) begin
      chk("wr_cycle", wr_at, op == SW ? 1 : 2);
      chk("wr_addr", 32'(wa), 32'(a));
      chk("wr_data", 32'(wdat), 32'(ref_mem[a[7:0]]));
    end
    tick;
    chk("rsp_drop", 32'(rsp_valid), 0);
    chk("idle_ready", 32'(req_ready), 1);
  endtask

  initial begin
    logic [16:0] r;
    int idx, nrsp, bad;
    logic [1:0] hop [3];
    logic [15:0] ha [3], hw [3];
    logic hs [3];
    tick;
    tick;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_mem", {mem_write_en, mem_read_en, mem_addr, mem_write_data}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", 32'(req_ready), 1);
    do_req(SW, 16'h0005, 1'b0, 16'hBEEF);
    do_req(LW, 16'h0005, 1'b0, 16'h0);
    do_req(SW, 16'h0007, 1'b0, 16'h1234);
    do_req(SB, 16'h0007, 1'b1, 16'h00AB);
    do_req(LB, 16'h0007, 1'b1, 16'h0);
    do_req(LB, 16'h0007, 1'b0, 16'h0);
    chk("lb_word7", 32'(mem[7]), 32'h0000AB34);
    do_req(SW, 16'h0100, 1'b0, 16'h1111);
    do_req(LB, 16'h0100, 1'b1, 16'h0);
    do_req(SW, 16'h00FF, 1'b0, 16'h8081);
    do_req(LB, 16'h00FF, 1'b0, 16'h0);
    // three requests with req_valid held high across the busy periods
    hop = '{SW, LW, LB}; ha = '{16'd20, 16'd20, 16'd20}; hs = '{1'b0, 1'b0, 1'b1};
    hw = '{16'($urandom), 16'h0, 16'h0};
    idx = 0; nrsp = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        nrsp++;
        if (eq.size() == 0) chk("hold_extra_rsp", 32'(rsp_valid), 0);
        else chk("hold_rsp", {15'h0, rsp_err, rsp_data}, 32'(eq.pop_front()));
      end
      if (req_ready && idx < 3) begin
        req_op = hop[idx]; req_addr = ha[idx]; req_byte_sel = hs[idx]; req_wdata = hw[idx];
        predict(hop[idx], ha[idx], hs[idx], hw[idx], r);
        eq.push_back(r);
        idx++;
      end else if (req_ready) req_valid = 1'b0;
      else scramble;
      tick;
    end
    chk("hold_count", nrsp, 3);
    // reset during the RMW write cycle must abort the byte store
    do_req(SW, 16'h0009, 1'b0, 16'h5555);
    req_valid = 1'b1; req_op = SB; req_addr = 16'h0009; req_byte_sel = 1'b0; req_wdata = 16'h00AA;
    tick;
    req_valid = 1'b0;
    chk("abort_rd", 32'(mem_read_en), 1);
    tick;
    chk("abort_wr_pre", 32'(mem_write_en), 1);
    rst = 1'b1;
    #1;
    chk("abort_wr_masked", {mem_write_en, mem_read_en, mem_addr}, 0);
    chk("abort_ready", 32'(req_ready), 0);
    tick;
    tick;
    rst = 1'b0;
    chk("abort_no_rsp", 32'(rsp_valid), 0);
    tick;
    chk("abort_idle", {rsp_valid, req_ready}, 1);
    chk("abort_word9", 32'(mem[9]), 32'h5555);
    do_req(LW, 16'h0009, 1'b0, 16'h0);
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [15:0] a;
      k = $urandom_range(0, 9);
      a = k == 0 ? 16'(256 + $urandom_range(0, 60000)) : k == 1 ? 16'h00FF : 16'($urandom_range(0, 15));
      do_req(2'($urandom), a, 1'($urandom), 16'($urandom));
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
